// File: rtl/round_robin_arbiter.sv
// round_robin_arbiter: registered round-robin arbiter with a one-hot grant under valid/ready
module round_robin_arbiter #(
    parameter int WIDTH = 8,
    localparam int INDEX_WIDTH = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic                   clock,
    input  logic                   resetn,
    input  logic [WIDTH-1:0]       requests,
    output logic [WIDTH-1:0]       grant,
    output logic [INDEX_WIDTH-1:0] grant_index,
    output logic                   grant_valid,
    input  logic                   grant_ready
);

    typedef enum logic {IDLE, GRANTED} state_t;

    state_t                 state_q, state_d;
    logic [INDEX_WIDTH-1:0] pointer_q, pointer_d;
    logic [INDEX_WIDTH-1:0] grant_index_q, grant_index_d;
    logic [WIDTH-1:0]       grant_q, grant_d;
    logic [INDEX_WIDTH-1:0] next_pointer, sel_pointer, sel_index;
    logic [WIDTH-1:0]       masked, sel_grant;
    logic                   accept;

    assign accept       = (state_q == GRANTED) && grant_ready;
    assign next_pointer = (grant_index_q == INDEX_WIDTH'(WIDTH - 1)) ? '0 : grant_index_q + INDEX_WIDTH'(1);
    // On accept the new pointer already governs the back-to-back selection
    assign sel_pointer  = accept ? next_pointer : pointer_q;

    // Mask requests below the pointer, then take the lowest set bit (falling back to unmasked)
    always_comb begin
        masked    = requests & ({WIDTH{1'b1}} << sel_pointer);
        sel_grant = (masked != '0) ? (masked & -masked) : (requests & -requests);
        sel_index = '0;
        for (int i = 0; i < WIDTH; i++) sel_index = sel_grant[i] ? INDEX_WIDTH'(i) : sel_index;
    end

    // Next-state: load a grant from IDLE, hold while stalled, reload or drop on accept
    always_comb begin
        state_d       = state_q;
        pointer_d     = pointer_q;
        grant_d       = grant_q;
        grant_index_d = grant_index_q;
        if (state_q == IDLE) begin
            if (requests != '0) begin
                state_d       = GRANTED;
                grant_d       = sel_grant;
                grant_index_d = sel_index;
            end
        end else if (accept) begin
            pointer_d     = next_pointer;
            grant_d       = sel_grant;
            grant_index_d = sel_index;
            state_d       = (sel_grant != '0) ? GRANTED : IDLE;
        end
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q       <= IDLE;
            pointer_q     <= '0;
            grant_q       <= '0;
            grant_index_q <= '0;
        end else begin
            state_q       <= state_d;
            pointer_q     <= pointer_d;
            grant_q       <= grant_d;
            grant_index_q <= grant_index_d;
        end
    end

    assign grant       = grant_q;
    assign grant_index = grant_index_q;
    assign grant_valid = (state_q == GRANTED);

endmodule

// File: tb/tb_round_robin_arbiter.sv
// tb_round_robin_arbiter: directed and random checks of the arbiter against a circular-search model
module tb_round_robin_arbiter;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         resetn = 1'b0;
    logic [W-1:0] requests = '0;
    logic         grant_ready = 1'b0;
    logic [W-1:0] grant;
    logic [1:0]   grant_index;
    logic         grant_valid;

    int total = 0;
    int passed = 0;
    int failed = 0;

    int m_valid = 0;
    int m_idx = 0;
    int m_ptr = 0;

    round_robin_arbiter #(.WIDTH(W)) dut (
        .clock(clk),
        .resetn(resetn),
        .requests(requests),
        .grant(grant),
        .grant_index(grant_index),
        .grant_valid(grant_valid),
        .grant_ready(grant_ready)
    );

    always #5 clk = ~clk;

    // First requester at or after p going around the ring; -1 when none
    function automatic int pick(input int p, input logic [W-1:0] r);
        for (int k = 0; k < W; k++) begin
            int j;
            j = (p + k) % W;
            if (r[j]) return j;
        end
        return -1;
    endfunction

    function automatic void model_reset();
        m_valid = 0;
        m_idx = 0;
        m_ptr = 0;
    endfunction

    function automatic void model_edge(input logic [W-1:0] r, input logic rdy);
        int j;
        if (m_valid == 0) begin
            j = pick(m_ptr, r);
            if (j >= 0) begin
                m_valid = 1;
                m_idx = j;
            end
        end else if (rdy) begin
            m_ptr = (m_idx + 1) % W;
            j = pick(m_ptr, r);
            m_valid = (j >= 0) ? 1 : 0;
            m_idx = (j >= 0) ? j : 0;
        end
    endfunction

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        assert (act === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic check_model(input string tag);
        check({tag, ".grant"}, 32'(grant), m_valid ? (32'd1 << m_idx) : 32'd0);
        check({tag, ".index"}, 32'(grant_index), 32'(m_idx));
        check({tag, ".valid"}, 32'(grant_valid), 32'(m_valid));
    endtask

    // Called at a negedge: drive inputs, cross one rising edge, check, return at the next negedge
    task automatic step(input string tag, input logic [W-1:0] r, input logic rdy);
        requests = r;
        grant_ready = rdy;
        model_edge(r, rdy);
        @(posedge clk);
        #1;
        check_model(tag);
        @(negedge clk);
    endtask

    initial begin
        requests = 4'b1111;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            check("rst.grant", 32'(grant), 0);
            check("rst.index", 32'(grant_index), 0);
            check("rst.valid", 32'(grant_valid), 0);
        end
        @(negedge clk);
        resetn = 1'b1;
        model_reset();
        step("first", 4'b1111, 1'b0);
        check("first.lit", 32'(grant), 32'b0001);

        for (int c = 0; c < 4; c++) step("rotate", 4'b1111, 1'b1);
        check("rotate.wrap", 32'(grant), 32'b0001);

        for (int c = 0; c < 4; c++) step("sparse", 4'b0101, 1'b1);
        check("sparse.lit", 32'(grant), 32'b0001);

        step("drain", 4'b0000, 1'b1);
        step("bp.load", 4'b0110, 1'b0);
        check("bp.lit", 32'(grant), 32'b0010);
        step("bp.hold", 4'b0110, 1'b0);
        step("bp.hold", 4'b0110, 1'b0);
        step("bp.chg", 4'b1000, 1'b0);
        check("bp.chg.lit", 32'(grant), 32'b0010);
        step("bp.acc", 4'b1000, 1'b1);
        check("bp.acc.lit", 32'(grant), 32'b1000);
        step("bp.idle", 4'b0000, 1'b1);
        check("bp.idle.lit", 32'(grant_valid), 0);
        step("idle.rdy", 4'b0000, 1'b1);

        step("mr.a", 4'b0010, 1'b0);
        step("mr.b", 4'b0100, 1'b1);
        check("mr.pre", 32'(grant), 32'b0100);
        grant_ready = 1'b0;
        #3;
        resetn = 1'b0;
        model_reset();
        #1;
        check("mr.grant", 32'(grant), 0);
        check("mr.index", 32'(grant_index), 0);
        check("mr.valid", 32'(grant_valid), 0);
        @(negedge clk);
        resetn = 1'b1;
        step("mr.after", 4'b1100, 1'b0);
        check("mr.after.lit", 32'(grant), 32'b0100);

        for (int c = 0; c < 4; c++) step("single", 4'b1000, 1'b1);
        check("single.lit", 32'(grant_index), 3);
        step("single.drop", 4'b0000, 1'b1);
        check("single.drop.lit", 32'(grant_valid), 0);

        for (int c = 0; c < 300; c++) step("rand", W'($urandom), 1'($urandom_range(0, 3) != 0));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
